// File: rtl/multicycle_add_sub.sv
// multicycle_add_sub
//   Sliced adder/subtractor. Computes x+y+cIn (sub=0) or x-y (sub=1) over
//   WIDTH bits, SLICE bits per clock, with one carry register between slices.
//   Latency is NS+1 cycles from an accepted start, where NS = WIDTH/SLICE.
//
// Handshake: start is sampled only while IDLE. An accepted start latches the
//   operands. busy is high for the NS cycles of slice processing. done pulses
//   for exactly one cycle when s/cOut/overflow have just been updated. A start
//   that is high in the done cycle is accepted, so back-to-back operations run
//   one per NS+1 cycles. A start that arrives while busy is ignored.
//
// Ports
//   Clk       in   clock, rising edge
//   Reset_n   in   asynchronous active-low reset
//   start     in   operation request
//   sub       in   0: x+y+cIn, 1: x-y (cIn ignored)
//   x, y      in   operands, latched on an accepted start
//   cIn       in   carry-in for add mode
//   busy      out  slices in progress
//   done      out  one-cycle result-valid pulse
//   s         out  result register, holds until the next done
//   cOut      out  carry out of the MSB (in sub mode, 1 = no borrow)
//   overflow  out  signed overflow of the last operation
//   dbgState  out  FSM state (0 = IDLE, 1 = RUN)
module multicycle_add_sub #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cOut,
    output logic             overflow,
    output logic             dbgState
);

    localparam int NS = WIDTH / SLICE;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(NS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stateType;

    stateType         state;
    stateType         nextState;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] xReg;
    logic [WIDTH-1:0] yReg;     // already inverted in subtract mode
    logic             carry;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] accNext;
    logic [SLICE:0]   sliceSum;
    logic             lastSlice;
    logic             carryIntoMsb;

    // One slice of the ripple chain, plus the accumulator with that slice
    // written in so the final edge can copy the complete result.
    always_comb begin
        sliceSum = {1'b0, xReg[count*SLICE +: SLICE]}
                 + {1'b0, yReg[count*SLICE +: SLICE]}
                 + {{SLICE{1'b0}}, carry};
        accNext = acc;
        accNext[count*SLICE +: SLICE] = sliceSum[SLICE-1:0];
        // Sum bit = a ^ b ^ cin, so the carry into the MSB is recoverable
        // from the MSB of the sum and of both operands.
        carryIntoMsb = accNext[WIDTH-1] ^ xReg[WIDTH-1] ^ yReg[WIDTH-1];
        lastSlice = (count == LAST_SLICE);
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = RUN;
            RUN:     if (lastSlice) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count    <= '0;
            xReg     <= '0;
            yReg     <= '0;
            carry    <= 1'b0;
            acc      <= '0;
            s        <= '0;
            cOut     <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        xReg  <= x;
                        yReg  <= sub ? ~y : y;
                        carry <= sub ? 1'b1 : cIn;
                        count <= '0;
                        acc   <= '0;
                    end
                end
                RUN: begin
                    acc   <= accNext;
                    carry <= sliceSum[SLICE];
                    if (lastSlice) begin
                        s        <= accNext;
                        cOut     <= sliceSum[SLICE];
                        overflow <= sliceSum[SLICE] ^ carryIntoMsb;
                        done     <= 1'b1;
                        count    <= '0;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state == RUN);
    assign dbgState = state;

endmodule
